// File: rtl/rggen_external_bridge.sv
// rggen_external_bridge: forwards register requests in one address window to a slow valid/ready peripheral
module rggen_external_bridge #(
    parameter int                       ADDRESS_WIDTH  = 8,
    parameter int                       BUS_WIDTH      = 32,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS  = '0,
    parameter int                       BYTE_SIZE      = 16,
    parameter int                       TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_register_valid,
    input  logic [1:0]               i_register_access,
    input  logic [ADDRESS_WIDTH-1:0] i_register_address,
    input  logic [BUS_WIDTH-1:0]     i_register_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_register_strobe,
    output logic                     o_register_active,
    output logic                     o_register_ready,
    output logic [1:0]               o_register_status,
    output logic [BUS_WIDTH-1:0]     o_register_read_data,
    output logic                     o_external_valid,
    output logic [1:0]               o_external_access,
    output logic [ADDRESS_WIDTH-1:0] o_external_address,
    output logic [BUS_WIDTH-1:0]     o_external_data,
    output logic [BUS_WIDTH/8-1:0]   o_external_strobe,
    input  logic                     i_external_ready,
    input  logic [1:0]               i_external_status,
    input  logic [BUS_WIDTH-1:0]     i_external_data
);
    localparam int SW = BUS_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [ADDRESS_WIDTH:0] WIN_LO = {1'b0, START_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0] WIN_HI = WIN_LO + (ADDRESS_WIDTH + 1)'(BYTE_SIZE - 1);
    typedef enum logic [1:0] {IDLE, REQUEST, RESPONSE} state_t;
    state_t                   state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic                     valid_q, valid_d;
    logic [1:0]               access_q, access_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [BUS_WIDTH-1:0]     data_q, data_d;
    logic [SW-1:0]            strobe_q, strobe_d;
    logic                     ready_q, ready_d;
    logic [1:0]               status_q, status_d;
    logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
    logic                     timeout;
    // Window compare is done one bit wider so a window touching the top of the address space cannot wrap.
    assign o_register_active = ({1'b0, i_register_address} >= WIN_LO) && ({1'b0, i_register_address} <= WIN_HI);
    assign timeout = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign o_register_ready = ready_q;
    assign o_register_status = status_q;
    assign o_register_read_data = rdata_q;
    assign o_external_valid = valid_q;
    assign o_external_access = access_q;
    assign o_external_address = address_q;
    assign o_external_data = data_q;
    assign o_external_strobe = strobe_q;
    // Next-state logic; response registers hold nonzero values only during the single RESPONSE cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        valid_d   = valid_q;
        access_d  = access_q;
        address_d = address_q;
        data_d    = data_q;
        strobe_d  = strobe_q;
        ready_d   = 1'b0;
        status_d  = 2'b00;
        rdata_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (i_register_valid && o_register_active) begin
                    state_d   = REQUEST;
                    valid_d   = 1'b1;
                    access_d  = i_register_access;
                    address_d = i_register_address - START_ADDRESS;
                    data_d    = i_register_write_data;
                    strobe_d  = i_register_strobe;
                    timer_d   = '0;
                end
            end
            REQUEST: begin
                if (i_external_ready || timeout) begin
                    state_d  = RESPONSE;
                    valid_d  = 1'b0;
                    ready_d  = 1'b1;
                    status_d = i_external_ready ? i_external_status : 2'b10;
                    rdata_d  = (i_external_ready && !access_q[0]) ? i_external_data : '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            access_q  <= '0;
            address_q <= '0;
            data_q    <= '0;
            strobe_q  <= '0;
            ready_q   <= 1'b0;
            status_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            access_q  <= access_d;
            address_q <= address_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            ready_q   <= ready_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_rggen_external_bridge.sv
// tb_rggen_external_bridge: randomized and directed checks of the bridge against a transaction-level model
module tb_rggen_external_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rv = 1'b0;
    logic [1:0] racc = '0;
    logic [7:0] raddr = '0;
    logic [31:0] rwd = '0;
    logic [3:0] rsb = '0;
    logic xr = 1'b0;
    logic [1:0] xs = '0;
    logic [31:0] xd = '0;
    logic act1, rdy1, xv1, act2, rdy2, xv2;
    logic [1:0] sts1, xacc1, sts2, xacc2;
    logic [31:0] rdat1, xdat1, rdat2, xdat2;
    logic [7:0] xa1, xa2;
    logic [3:0] xstb1, xstb2;
    int total = 0;
    int bad = 0;
    int nv, nr, rc, nv2, nr2, rc2;
    logic [1:0] st, st2, o_acc;
    logic [31:0] rdo, rdo2, o_data;
    logic [7:0] o_addr;
    logic [3:0] o_strb;
    logic act;
    bit frozen_bad, zero_bad;

    rggen_external_bridge #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .START_ADDRESS(8'h40), .BYTE_SIZE(16), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_register_valid(rv), .i_register_access(racc), .i_register_address(raddr),
        .i_register_write_data(rwd), .i_register_strobe(rsb), .o_register_active(act1), .o_register_ready(rdy1),
        .o_register_status(sts1), .o_register_read_data(rdat1), .o_external_valid(xv1), .o_external_access(xacc1),
        .o_external_address(xa1), .o_external_data(xdat1), .o_external_strobe(xstb1), .i_external_ready(xr),
        .i_external_status(xs), .i_external_data(xd));

    rggen_external_bridge #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .START_ADDRESS(8'h40), .BYTE_SIZE(16), .TIMEOUT_CYCLES(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_register_valid(rv), .i_register_access(racc), .i_register_address(raddr),
        .i_register_write_data(rwd), .i_register_strobe(rsb), .o_register_active(act2), .o_register_ready(rdy2),
        .o_register_status(sts2), .o_register_read_data(rdat2), .o_external_valid(xv2), .o_external_access(xacc2),
        .o_external_address(xa2), .o_external_data(xdat2), .o_external_strobe(xstb2), .i_external_ready(xr),
        .i_external_status(xs), .i_external_data(xd));

    always #5 clk = ~clk;

    // Cycles the request stays outstanding: the ready cycle if it comes in time, else the full timeout.
    function automatic int exp_nv(input int t, input int d);
        return (d >= 1 && d <= t) ? d : t;
    endfunction

    function automatic bit exp_to(input int t, input int d);
        return !(d >= 1 && d <= t);
    endfunction

    function automatic bit in_win(input logic [7:0] a);
        return int'(a) >= 'h40 && int'(a) < 'h40 + 16;
    endfunction

    // Issues one request and records what both bridges do; d is the REQUEST cycle carrying external ready (0 = never).
    task automatic drive(input logic [7:0] a, input logic [1:0] acc, input logic [31:0] wd, input logic [3:0] sb,
                         input int d, input logic [1:0] est, input logic [31:0] edat, input int win, input int noise_lim);
        @(negedge clk);
        raddr = a; racc = acc; rwd = wd; rsb = sb; rv = 1'b1; xr = 1'b0;
        nv = 0; nr = 0; rc = -1; nv2 = 0; nr2 = 0; rc2 = -1;
        st = 2'bxx; st2 = 2'bxx; rdo = 'x; rdo2 = 'x;
        o_addr = 'x; o_acc = 'x; o_data = 'x; o_strb = 'x;
        frozen_bad = 1'b0; zero_bad = 1'b0;
        #1 act = act1;
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            rv = (c <= noise_lim) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c <= noise_lim) begin
                rwd = $urandom; rsb = 4'($urandom); racc = 2'($urandom);
            end
            xr = (c == d);
            xs = (c == d) ? est : 2'($urandom);
            xd = (c == d) ? edat : $urandom;
            if (xv1) begin
                if (nv == 0) begin
                    o_addr = xa1; o_acc = xacc1; o_data = xdat1; o_strb = xstb1;
                end else if (xa1 !== o_addr || xacc1 !== o_acc || xdat1 !== o_data || xstb1 !== o_strb) begin
                    frozen_bad = 1'b1;
                end
                nv++;
            end
            if (rdy1) begin
                nr++; rc = c; st = sts1; rdo = rdat1;
            end else if (sts1 !== 2'b00 || rdat1 !== 32'h0) begin
                zero_bad = 1'b1;
            end
            if (xv2) nv2++;
            if (rdy2) begin
                nr2++; rc2 = c; st2 = sts2; rdo2 = rdat2;
            end else if (sts2 !== 2'b00 || rdat2 !== 32'h0) begin
                zero_bad = 1'b1;
            end
        end
        xr = 1'b0; rv = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (xv1 !== 1'b0) begin bad++; $display("FAIL reset_ext_valid got=%0b exp=0", xv1); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", rdy1); end
        total++; if (sts1 !== 2'b00 || rdat1 !== 32'h0) begin bad++; $display("FAIL reset_resp got=%0h/%0h exp=0/0", sts1, rdat1); end
        total++; if ({xacc1, xa1, xdat1, xstb1} !== 46'h0) begin bad++; $display("FAIL reset_ext_fields got=%0h/%0h/%0h/%0h exp=0", xacc1, xa1, xdat1, xstb1); end
        rst = 1'b0;
    endtask

    task automatic test_active_bounds;
        logic [7:0] addrs [6];
        addrs = '{8'h3F, 8'h40, 8'h4F, 8'h50, 8'h00, 8'hFF};
        foreach (addrs[i]) begin
            @(negedge clk);
            raddr = addrs[i];
            #1;
            total++; if (act1 !== in_win(addrs[i])) begin bad++; $display("FAIL active_%0h got=%0b exp=%0b", addrs[i], act1, in_win(addrs[i])); end
        end
    endtask

    task automatic test_read_hit;
        drive(8'h44, 2'b00, 32'h0, 4'hF, 3, 2'b00, 32'hDEADBEEF, 4, 3);
        total++; if (act !== 1'b1) begin bad++; $display("FAIL read_active got=%0b exp=1", act); end
        total++; if (o_addr !== 8'h04) begin bad++; $display("FAIL read_ext_addr got=%0h exp=04", o_addr); end
        total++; if (o_acc !== 2'b00) begin bad++; $display("FAIL read_ext_access got=%0h exp=0", o_acc); end
        total++; if (nv !== 3 || frozen_bad) begin bad++; $display("FAIL read_valid_cycles got=%0d frozen_bad=%0b exp=3", nv, frozen_bad); end
        total++; if (nr !== 1 || rc !== 4) begin bad++; $display("FAIL read_ready got=%0d@%0d exp=1@4", nr, rc); end
        total++; if (st !== 2'b00 || rdo !== 32'hDEADBEEF) begin bad++; $display("FAIL read_resp got=%0h/%0h exp=0/deadbeef", st, rdo); end
        total++; if (zero_bad) begin bad++; $display("FAIL read_idle_zero got=1 exp=0"); end
    endtask

    task automatic test_write;
        drive(8'h48, 2'b01, 32'h12345678, 4'b0011, 1, 2'b00, 32'hCAFEF00D, 2, 0);
        total++; if (o_addr !== 8'h08 || o_acc !== 2'b01) begin bad++; $display("FAIL write_ext_addr_acc got=%0h/%0h exp=08/1", o_addr, o_acc); end
        total++; if (o_data !== 32'h12345678 || o_strb !== 4'b0011) begin bad++; $display("FAIL write_ext_data got=%0h/%0h exp=12345678/3", o_data, o_strb); end
        total++; if (nv !== 1 || nr !== 1 || rc !== 2) begin bad++; $display("FAIL write_latency got=nv%0d nr%0d @%0d exp=nv1 nr1 @2", nv, nr, rc); end
        total++; if (st !== 2'b00 || rdo !== 32'h0) begin bad++; $display("FAIL write_resp got=%0h/%0h exp=0/0", st, rdo); end
    endtask

    task automatic test_timeout;
        drive(8'h4C, 2'b00, 32'h0, 4'hF, 0, 2'b00, 32'h0, 5, 0);
        total++; if (nv !== 4) begin bad++; $display("FAIL timeout_valid_cycles got=%0d exp=4", nv); end
        total++; if (nr !== 1 || rc !== 5) begin bad++; $display("FAIL timeout_ready got=%0d@%0d exp=1@5", nr, rc); end
        total++; if (st !== 2'b10 || rdo !== 32'h0) begin bad++; $display("FAIL timeout_resp got=%0h/%0h exp=2/0", st, rdo); end
        total++; if (nv2 !== 2 || rc2 !== 3 || st2 !== 2'b10) begin bad++; $display("FAIL timeout2 got=nv%0d @%0d st%0h exp=nv2 @3 st2", nv2, rc2, st2); end
    endtask

    task automatic test_miss;
        drive(8'h60, 2'b00, 32'h0, 4'hF, 2, 2'b00, 32'h1111, 6, 0);
        total++; if (act !== 1'b0) begin bad++; $display("FAIL miss_active got=%0b exp=0", act); end
        total++; if (nv !== 0 || nr !== 0 || nv2 !== 0 || nr2 !== 0) begin bad++; $display("FAIL miss_quiet got=nv%0d nr%0d nv2%0d nr2%0d exp=0", nv, nr, nv2, nr2); end
        drive(8'h42, 2'b00, 32'h0, 4'hF, 1, 2'b01, 32'h7777, 2, 0);
        total++; if (nv !== 1 || rc !== 2 || st !== 2'b01 || rdo !== 32'h7777) begin bad++; $display("FAIL miss_then_hit got=nv%0d @%0d %0h/%0h exp=nv1 @2 1/7777", nv, rc, st, rdo); end
    endtask

    task automatic test_ready_and_timeout;
        drive(8'h41, 2'b10, 32'h0, 4'hF, 2, 2'b01, 32'h55AA55AA, 3, 0);
        total++; if (nv2 !== 2 || nr2 !== 1 || rc2 !== 3) begin bad++; $display("FAIL tie_timing got=nv%0d nr%0d @%0d exp=nv2 nr1 @3", nv2, nr2, rc2); end
        total++; if (st2 !== 2'b01 || rdo2 !== 32'h55AA55AA) begin bad++; $display("FAIL tie_resp got=%0h/%0h exp=1/55aa55aa", st2, rdo2); end
        total++; if (st !== 2'b01 || rdo !== 32'h55AA55AA) begin bad++; $display("FAIL tie_resp_dut4 got=%0h/%0h exp=1/55aa55aa", st, rdo); end
    endtask

    task automatic test_back_to_back;
        drive(8'h40, 2'b00, 32'h0, 4'hF, 1, 2'b00, 32'hA0A0A0A0, 2, 0);
        drive(8'h4F, 2'b01, 32'hBBBB, 4'h1, 1, 2'b11, 32'h0, 2, 0);
        total++; if (nv !== 1 || rc !== 2 || o_addr !== 8'h0F) begin bad++; $display("FAIL b2b_second got=nv%0d @%0d addr%0h exp=nv1 @2 addr0f", nv, rc, o_addr); end
        total++; if (st !== 2'b11 || rdo !== 32'h0) begin bad++; $display("FAIL b2b_resp got=%0h/%0h exp=3/0", st, rdo); end
    endtask

    task automatic test_reset_mid;
        int cnt_v, cnt_r;
        @(negedge clk);
        raddr = 8'h42; racc = 2'b00; rv = 1'b1;
        @(negedge clk);
        rv = 1'b0;
        @(negedge clk);
        total++; if (xv1 !== 1'b1) begin bad++; $display("FAIL rstmid_in_request got=%0b exp=1", xv1); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (xv1 !== 1'b0 || rdy1 !== 1'b0) begin bad++; $display("FAIL rstmid_after_reset got=%0b/%0b exp=0/0", xv1, rdy1); end
        rst = 1'b0; xr = 1'b1; xs = 2'b00; xd = 32'h12121212;
        @(negedge clk);
        xr = 1'b0;
        cnt_v = 0; cnt_r = 0;
        repeat (5) begin
            @(negedge clk);
            cnt_v += int'(xv1); cnt_r += int'(rdy1);
        end
        total++; if (cnt_r !== 0 || cnt_v !== 0) begin bad++; $display("FAIL rstmid_late_ready got=ready%0d valid%0d exp=0/0", cnt_r, cnt_v); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 60; it++) begin
            logic [7:0] a;
            logic [1:0] acc, est;
            logic [31:0] wd, edat;
            int d, e1, e2, lim;
            bit hit;
            a = $urandom_range(0, 1) ? 8'h40 + 8'($urandom_range(0, 15)) : 8'($urandom);
            acc = 2'($urandom); est = 2'($urandom); wd = $urandom; edat = $urandom;
            d = $urandom_range(0, 6);
            hit = in_win(a);
            e1 = exp_nv(4, d);
            e2 = exp_nv(2, d);
            lim = hit ? ((e1 < e2 ? e1 : e2) + 1) : 0;
            drive(a, acc, wd, 4'($urandom), d, est, edat, hit ? e1 + 1 : 4, lim);
            total++; if (act !== hit) begin bad++; $display("FAIL rnd%0d_active got=%0b exp=%0b", it, act, hit); end
            if (hit) begin
                total++; if (nv !== e1 || frozen_bad) begin bad++; $display("FAIL rnd%0d_valid got=%0d frozen_bad=%0b exp=%0d", it, nv, frozen_bad, e1); end
                total++; if (o_addr !== a - 8'h40) begin bad++; $display("FAIL rnd%0d_offset got=%0h exp=%0h", it, o_addr, a - 8'h40); end
                total++; if (o_data !== wd || o_acc !== acc) begin bad++; $display("FAIL rnd%0d_req got=%0h/%0h exp=%0h/%0h", it, o_data, o_acc, wd, acc); end
                total++; if (nr !== 1 || rc !== e1 + 1) begin bad++; $display("FAIL rnd%0d_ready got=%0d@%0d exp=1@%0d", it, nr, rc, e1 + 1); end
                total++; if (st !== (exp_to(4, d) ? 2'b10 : est) || rdo !== ((exp_to(4, d) || acc[0]) ? 32'h0 : edat)) begin
                    bad++; $display("FAIL rnd%0d_resp got=%0h/%0h d=%0d acc=%0h est=%0h edat=%0h", it, st, rdo, d, acc, est, edat);
                end
                total++; if (nv2 !== e2 || nr2 !== 1 || rc2 !== e2 + 1) begin bad++; $display("FAIL rnd%0d_t2_timing got=nv%0d nr%0d @%0d exp=nv%0d nr1 @%0d", it, nv2, nr2, rc2, e2, e2 + 1); end
                total++; if (st2 !== (exp_to(2, d) ? 2'b10 : est) || rdo2 !== ((exp_to(2, d) || acc[0]) ? 32'h0 : edat)) begin
                    bad++; $display("FAIL rnd%0d_t2_resp got=%0h/%0h d=%0d acc=%0h est=%0h edat=%0h", it, st2, rdo2, d, acc, est, edat);
                end
                total++; if (zero_bad) begin bad++; $display("FAIL rnd%0d_idle_zero got=1 exp=0", it); end
            end else begin
                total++; if (nv !== 0 || nr !== 0 || nv2 !== 0 || nr2 !== 0) begin bad++; $display("FAIL rnd%0d_miss got=nv%0d nr%0d nv2%0d nr2%0d exp=0", it, nv, nr, nv2, nr2); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_active_bounds();
        test_read_hit();
        test_write();
        test_timeout();
        test_miss();
        test_ready_and_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rggen_external_bridge.md
# rggen_external_bridge

Register-side responder for the register request interface driven by the bus adapter. Claims one address window, registers each request, and forwards it as a valid/ready transaction to an external slow peripheral. When the peripheral responds, or a timeout expires, it returns a one-cycle ready with status and read data to the adapter. It sits in the register block alongside ordinary registers and occupies one slot of the adapter's active/ready/status/read-data vectors.

## Interface
- ADDRESS_WIDTH, 8, width of register-side and external addresses
- BUS_WIDTH, 32, data width; strobe width BUS_WIDTH/8
- START_ADDRESS, 0, first byte address of the claimed window (ADDRESS_WIDTH bits)
- BYTE_SIZE, 16, window size in bytes
- TIMEOUT_CYCLES, 16, REQUEST-state cycles before abort; 0 disables timeout
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_register_valid  in  1  request pulse from adapter
- i_register_access  in  2  access type; bit 0 = 1 write, 0 read
- i_register_address  in  ADDRESS_WIDTH  byte address, held stable until ready
- i_register_write_data  in  BUS_WIDTH  write data
- i_register_strobe  in  BUS_WIDTH/8  byte enables
- o_register_active  out  1  address inside window
- o_register_ready  out  1  response pulse
- o_register_status  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
- o_register_read_data  out  BUS_WIDTH  read data
- o_external_valid  out  1  external request valid
- o_external_access  out  2  captured access
- o_external_address  out  ADDRESS_WIDTH  offset = address - START_ADDRESS (modulo 2^ADDRESS_WIDTH)
- o_external_data  out  BUS_WIDTH  captured write data
- o_external_strobe  out  BUS_WIDTH/8  captured strobe
- i_external_ready  in  1  external response
- i_external_status  in  2  external status
- i_external_data  in  BUS_WIDTH  external read data

## Operation
- o_register_active: combinational. START_ADDRESS <= i_register_address <= START_ADDRESS+BYTE_SIZE-1. Independent of state.
- States: IDLE, REQUEST, RESPONSE. Reset value IDLE.
- IDLE: i_register_valid && o_register_active -> capture access, offset, write data and strobe into request registers; clear timer; go to REQUEST. Valid outside the window is ignored. i_external_ready is ignored.
- REQUEST: o_external_valid=1; request registers are frozen.
  - i_external_ready=1 -> capture i_external_status. Capture i_external_data for reads, 0 for writes. Go to RESPONSE.
  - Otherwise the timer increments. When TIMEOUT_CYCLES!=0 and the timer reaches TIMEOUT_CYCLES-1 with no ready, capture status 2'b10 and data 0, drop o_external_valid, and go to RESPONSE.
  - Ready and timeout in the same cycle: ready wins.
- RESPONSE: o_register_ready=1 for exactly one cycle; status and read data come from the response registers. Next state is IDLE.
- i_register_valid in REQUEST or RESPONSE: ignored; no second capture.
- o_register_status = 00 and o_register_read_data = 0 whenever o_register_ready=0.
- Timer width: enough bits to hold TIMEOUT_CYCLES; it never wraps.

## Timing
- Reset values: o_external_valid 0, o_register_ready 0, o_register_status 00, o_register_read_data 0. All o_external_* data, address, strobe and access registers reset to 0.
- Request path: valid captured at edge N -> o_external_valid high from cycle N+1.
- Response path: i_external_ready at cycle K -> o_register_ready at K+1 -> state IDLE at K+2.
- Minimum latency from valid to ready: 2 cycles (external ready in the first REQUEST cycle).
- Timeout: o_external_valid is high for exactly TIMEOUT_CYCLES cycles, and o_register_ready follows on the next cycle.
- Back-to-back: a new valid is accepted in the IDLE cycle right after RESPONSE.
- Reset mid-transaction: next edge forces IDLE and drops o_external_valid and o_register_ready. A late i_external_ready is then ignored.

## Test plan
- Read hit, START_ADDRESS=0x40, address 0x44. External ready on the 3rd REQUEST cycle with data 0xDEADBEEF, status 00. Required: o_external_address=0x04; o_register_ready a single pulse with data 0xDEADBEEF, status 00.
- Write, strobe 4'b0011, data 0x12345678, external ready in the first REQUEST cycle. Required: external fields match the request; ready 2 cycles after valid; read data 0.
- Timeout: TIMEOUT_CYCLES=4, external ready never asserted. Required: o_external_valid high exactly 4 cycles; ready with status 10, data 0.
- Miss: address 0x60 with a 16-byte window. Required: o_register_active=0; o_external_valid never rises; state stays IDLE.
- Reset while in REQUEST, then external ready pulsed. Required: o_external_valid low after the reset edge; no o_register_ready.
- Ready and timeout in the same cycle: TIMEOUT_CYCLES=2, ready in the 2nd REQUEST cycle with status 01. Required: response status 01.
